// File: rtl/score_digit_renderer_if.sv
// score_digit_renderer_if: the renderer's raster, score, glyph ROM and pixel signals.
interface score_digit_renderer_if #(parameter int SCORE_W = 14);
  logic               video_on;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic               frame_tick;
  logic [SCORE_W-1:0] score_in;
  logic               score_load;
  logic               busy;
  logic [3:0]         digit_sel;
  logic [4:0]         rom_row;
  logic [4:0]         rom_col;
  logic [11:0]        rom_color;
  logic               pixel_on;
  logic [11:0]        pixel_rgb;
  modport master (
    output video_on, pixel_x, pixel_y, frame_tick, score_in, score_load, rom_color,
    input  busy, digit_sel, rom_row, rom_col, pixel_on, pixel_rgb
  );
  modport slave (
    input  video_on, pixel_x, pixel_y, frame_tick, score_in, score_load, rom_color,
    output busy, digit_sel, rom_row, rom_col, pixel_on, pixel_rgb
  );
endinterface

// File: rtl/score_digit_renderer.sv
// score_digit_renderer: double-dabble a binary score into BCD, commit it at frame_tick
// and draw it from the shared digit glyph ROM with leading-zero blanking.
module score_digit_renderer #(
  parameter int          NUM_DIGITS = 4,
  parameter int          SCORE_W    = 14,
  parameter int          X0         = 64,
  parameter int          Y0         = 16,
  parameter logic [11:0] FG_RGB     = 12'hFFF
) (
  input logic                  clk,
  input logic                  reset_n,
  score_digit_renderer_if.slave bus
);
  localparam int BW   = 4 * NUM_DIGITS;
  localparam int MAXI = 10 ** NUM_DIGITS - 1;
  localparam int CW   = $clog2(SCORE_W + 1);
  localparam logic [9:0] XL = 10'(X0);
  localparam logic [9:0] XH = 10'(X0 + 32 * NUM_DIGITS);
  localparam logic [9:0] YL = 10'(Y0);
  localparam logic [9:0] YH = 10'(Y0 + 32);
  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;
  state_t             state, state_n;
  logic [SCORE_W-1:0] bin, bin_n;
  logic [BW-1:0]      bcd, bcd_n, adj;
  logic [CW-1:0]      cnt, cnt_n;
  logic               commit;
  logic [3:0]         disp [NUM_DIGITS];
  logic [9:0]         dx;
  logic [4:0]         dy;
  logic               hit, lead, own_d1, on_next;
  logic [3:0]         sel;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      bin   <= bin_n;
      bcd   <= bcd_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    bin_n   = bin;
    bcd_n   = bcd;
    cnt_n   = cnt;
    commit  = 1'b0;
    adj     = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    case (state)
      IDLE: if (bus.score_load) begin
        state_n = CONVERT;
        bin_n   = 32'(bus.score_in) > MAXI ? SCORE_W'(MAXI) : bus.score_in;
        bcd_n   = '0;
        cnt_n   = '0;
      end
      CONVERT: begin
        bcd_n   = {adj[BW-2:0], bin[SCORE_W-1]};
        bin_n   = bin << 1;
        cnt_n   = cnt + 1'b1;
        state_n = cnt == CW'(SCORE_W - 1) ? HOLD : CONVERT;
      end
      HOLD: if (bus.frame_tick) begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.busy = state != IDLE;
  // disp[0] is the most significant digit; only updated in vertical blank
  always_ff @(posedge clk) begin
    if (!reset_n)
      for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= 4'd0;
    else if (commit)
      for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= bcd[4*(NUM_DIGITS-1-i) +: 4];
  end
  always_comb begin
    dx   = bus.pixel_x - XL;
    dy   = bus.pixel_y[4:0] - YL[4:0];
    hit  = bus.pixel_x >= XL && bus.pixel_x < XH && bus.pixel_y >= YL && bus.pixel_y < YH;
    sel  = 4'hF;
    lead = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead = lead & (disp[i] == 4'd0);
      if (hit && dx[9:5] == 5'(i) && !(lead && i != NUM_DIGITS - 1)) sel = disp[i];
    end
  end
  assign bus.rom_col = dx[4:0];
  assign bus.rom_row = dy;
  assign on_next     = own_d1 && bus.rom_color != 12'hFFF;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.digit_sel <= 4'hF;
      own_d1        <= 1'b0;
      bus.pixel_on  <= 1'b0;
      bus.pixel_rgb <= 12'h000;
    end else begin
      bus.digit_sel <= sel;
      own_d1        <= sel != 4'hF && bus.video_on;
      bus.pixel_on  <= on_next;
      bus.pixel_rgb <= on_next ? FG_RGB : 12'h000;
    end
  end
endmodule
